// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding, reusable by future
// APB interconnect/decoder blocks.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase cycle counter; 'expired' flags the last allowed
// ACCESS cycle so the master can abandon the transfer on the same edge.
module apb_timeout_cnt #(
    parameter int timeout = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int cnt_w  = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam int last_i = (timeout > 0) ? timeout - 1 : 0;
    localparam logic [cnt_w-1:0] limit = cnt_w'(timeout);
    localparam logic [cnt_w-1:0] last  = cnt_w'(last_i);

    logic [cnt_w-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Counter holds the number of completed ACCESS cycles, so the current
    // cycle is the timeout-th one when it equals timeout-1.
    assign expired = (timeout != 0) && en && (cnt == last);

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: one outstanding request at a time, sequenced through
// SETUP/ACCESS, with an optional pready timeout that forces an error response.
module apb_master
    import apb_pkg::*;
#(
    parameter int addr_w  = 5,
    parameter int timeout = 255
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [addr_w-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_write,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [addr_w-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr,
    output apb_mst_state_t    state
);

    // Handshakes: a request transfers on an edge where req_valid & req_ready;
    // a response transfers on an edge where rsp_valid & rsp_ready. Neither
    // ready depends combinationally on the matching valid.

    apb_mst_state_t cur_state, nxt_state;
    logic           accept;
    logic           expired;

    assign accept = (cur_state == IDLE) && req_valid;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (req_valid) nxt_state = SETUP;
            SETUP:   nxt_state = ACCESS;
            ACCESS:  if (pready || expired) nxt_state = RESP;
            RESP:    if (rsp_ready) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
        end else if (accept) begin
            paddr  <= req_addr;
            pwdata <= req_wdata;
            pwrite <= req_write;
        end
    end

    // pready wins over timeout when both occur in the last allowed cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (cur_state == ACCESS) begin
            if (pready) begin
                rsp_err   <= pslverr;
                rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'd0;
            end else if (expired) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= 32'd0;
            end
        end
    end

    apb_timeout_cnt #(
        .timeout (timeout)
    ) u_timeout_cnt (
        .clk     (pclk),
        .rst_n   (presetn),
        .clr     (accept),
        .en      (cur_state == ACCESS),
        .expired (expired)
    );

    // req_ready is gated by presetn so it stays 0 while reset is held.
    assign req_ready = (cur_state == IDLE) && presetn;
    assign psel      = (cur_state == SETUP) || (cur_state == ACCESS);
    assign penable   = (cur_state == ACCESS);
    assign rsp_valid = (cur_state == RESP);
    assign state     = cur_state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers checked
// against a transaction-level model (wait count -> access length, err, rdata).
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk;
    logic        presetn;

    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;
    apb_mst_state_t dbg_state;

    logic        t4_req_valid, t4_req_ready, t4_req_write;
    logic [4:0]  t4_req_addr;
    logic [31:0] t4_req_wdata;
    logic        t4_rsp_valid, t4_rsp_ready, t4_rsp_err;
    logic [31:0] t4_rsp_rdata;
    logic [4:0]  t4_paddr;
    logic [31:0] t4_pwdata, t4_prdata;
    logic        t4_pwrite, t4_psel, t4_penable, t4_pready, t4_pslverr;
    apb_mst_state_t t4_dbg_state;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];

    apb_master #(.addr_w(5), .timeout(0)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .state(dbg_state)
    );

    apb_master #(.addr_w(5), .timeout(4)) dut_t4 (
        .pclk(pclk), .presetn(presetn),
        .req_valid(t4_req_valid), .req_ready(t4_req_ready), .req_addr(t4_req_addr),
        .req_wdata(t4_req_wdata), .req_write(t4_req_write),
        .rsp_valid(t4_rsp_valid), .rsp_ready(t4_rsp_ready), .rsp_rdata(t4_rsp_rdata),
        .rsp_err(t4_rsp_err), .paddr(t4_paddr), .pwdata(t4_pwdata), .pwrite(t4_pwrite),
        .psel(t4_psel), .penable(t4_penable), .prdata(t4_prdata), .pready(t4_pready),
        .pslverr(t4_pslverr), .state(t4_dbg_state)
    );

    // Clock and reset
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one transfer on the timeout-disabled DUT; the slave side
    // raises pready after 'waits' ACCESS cycles. 'hold' cycles of rsp_ready=0
    // with a competing req_valid precede the response handshake.
    task automatic drive_xfer(input logic [4:0] a, input logic [31:0] wd, input logic wr,
                              input int waits, input logic serr, input logic [31:0] rd,
                              input int hold, input string tag);
        int          acc;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_acc = waits + 1;
        exp_err = serr;
        exp_rd  = (!wr && !serr) ? rd : 32'd0;

        @(negedge pclk);
        total++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s_req_ready: got %b want 1", tag, req_ready); bad++;
        end
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_write = wr;
        pready = 1'b0; pslverr = 1'b0;
        @(posedge pclk); #1;
        req_valid = 1'b0; req_addr = 5'($urandom); req_wdata = $urandom; req_write = 1'($urandom);

        @(negedge pclk);
        total++;
        if ({psel, penable, paddr, pwdata, pwrite} !== {1'b1, 1'b0, a, wd, wr}) begin
            $display("FAIL %s_setup: psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b want 1 0 %h %h %b",
                     tag, psel, penable, paddr, pwdata, pwrite, a, wd, wr); bad++;
        end

        acc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge pclk);
            if (!(psel === 1'b1 && penable === 1'b1)) break;
            acc++;
            if ({paddr, pwdata, pwrite} !== {a, wd, wr}) begin
                total++;
                $display("FAIL %s_access_hold: paddr=%h pwdata=%h pwrite=%b want %h %h %b",
                         tag, paddr, pwdata, pwrite, a, wd, wr); bad++;
            end
            pready = (acc > waits); pslverr = serr; prdata = rd;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;

        total++;
        if (acc !== exp_acc) begin
            $display("FAIL %s_access_len: got %0d want %0d", tag, acc, exp_acc); bad++;
        end
        total++;
        if ({rsp_valid, psel, penable, req_ready} !== 4'b1000) begin
            $display("FAIL %s_resp_flags: rsp_valid=%b psel=%b penable=%b req_ready=%b want 1 0 0 0",
                     tag, rsp_valid, psel, penable, req_ready); bad++;
        end
        total++;
        if ({rsp_err, rsp_rdata} !== {exp_err, exp_rd}) begin
            $display("FAIL %s_resp_data: err=%b rdata=%h want %b %h", tag, rsp_err, rsp_rdata, exp_err, exp_rd); bad++;
        end

        for (int j = 0; j < hold; j++) begin
            req_valid = 1'b1; req_addr = 5'($urandom); req_write = 1'($urandom);
            @(negedge pclk);
            total++;
            if ({rsp_valid, req_ready, psel, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, exp_err, exp_rd}) begin
                $display("FAIL %s_hold: rsp_valid=%b req_ready=%b psel=%b err=%b rdata=%h want 1 0 0 %b %h",
                         tag, rsp_valid, req_ready, psel, rsp_err, rsp_rdata, exp_err, exp_rd); bad++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        @(negedge pclk);
        total++;
        if ({rsp_valid, req_ready, psel} !== 3'b010) begin
            $display("FAIL %s_release: rsp_valid=%b req_ready=%b psel=%b want 0 1 0",
                     tag, rsp_valid, req_ready, psel); bad++;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        t4_req_valid = 1'b0; t4_req_addr = '0; t4_req_wdata = '0; t4_req_write = 1'b0;
        t4_rsp_ready = 1'b0; t4_prdata = '0; t4_pready = 1'b0; t4_pslverr = 1'b0;
        #12;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwdata, pwrite, psel, penable} !== '0) begin
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b err=%b rdata=%h paddr=%h pwdata=%h pwrite=%b psel=%b penable=%b want all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwdata, pwrite, psel, penable); bad++;
        end
        total++;
        if ({t4_req_ready, t4_psel, t4_penable, t4_rsp_valid} !== 4'b0) begin
            $display("FAIL reset_outputs_t4: req_ready=%b psel=%b penable=%b rsp_valid=%b want 0",
                     t4_req_ready, t4_psel, t4_penable, t4_rsp_valid); bad++;
        end
        @(negedge pclk); #2;
        presetn = 1'b1;
        @(negedge pclk);
        total++;
        if ({req_ready, psel, rsp_valid} !== 3'b100) begin
            $display("FAIL reset_release: req_ready=%b psel=%b rsp_valid=%b want 1 0 0", req_ready, psel, rsp_valid); bad++;
        end
    endtask

    task automatic test_write_basic();
        drive_xfer(5'h04, 32'h0000_00A5, 1'b1, 0, 1'b0, $urandom, 0, "write_basic");
    endtask

    task automatic test_read_wait();
        drive_xfer(5'h10, $urandom, 1'b0, 3, 1'b0, 32'h1234_5678, 0, "read_wait");
    endtask

    task automatic test_slverr();
        drive_xfer(5'($urandom), $urandom, 1'b0, 0, 1'b1, 32'hDEAD_BEEF, 0, "slverr_read");
        drive_xfer(5'($urandom), $urandom, 1'b1, 2, 1'b1, 32'hDEAD_BEEF, 0, "slverr_write");
    endtask

    task automatic test_no_timeout();
        drive_xfer(5'h1F, $urandom, 1'b0, 300, 1'b0, 32'hCAFE_F00D, 0, "no_timeout");
    endtask

    task automatic test_resp_hold();
        drive_xfer(5'h0A, $urandom, 1'b0, 1, 1'b0, 32'h5A5A_0F0F, 5, "resp_hold");
    endtask

    // Timeout=4 DUT: a dead slave, then a slave answering in the 4th cycle.
    task automatic test_timeout();
        int          waits;
        int          acc;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        for (int s = 0; s < 2; s++) begin
            waits   = (s == 0) ? 1000 : 3;
            rd      = $urandom;
            exp_err = (waits >= 4);
            exp_acc = exp_err ? 4 : waits + 1;
            exp_rd  = exp_err ? 32'd0 : rd;
            @(negedge pclk);
            t4_req_valid = 1'b1; t4_req_addr = 5'($urandom); t4_req_wdata = $urandom; t4_req_write = 1'b0;
            @(posedge pclk); #1;
            t4_req_valid = 1'b0;
            @(negedge pclk);
            acc = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge pclk);
                if (!(t4_psel === 1'b1 && t4_penable === 1'b1)) break;
                acc++;
                t4_pready = (acc > waits); t4_prdata = rd; t4_pslverr = 1'b0;
            end
            t4_pready = 1'b0;
            total++;
            if (acc !== exp_acc) begin
                $display("FAIL timeout_len_%0d: got %0d want %0d", s, acc, exp_acc); bad++;
            end
            total++;
            if ({t4_rsp_valid, t4_psel, t4_penable, t4_rsp_err, t4_rsp_rdata} !== {3'b100, exp_err, exp_rd}) begin
                $display("FAIL timeout_resp_%0d: rsp_valid=%b psel=%b penable=%b err=%b rdata=%h want 1 0 0 %b %h",
                         s, t4_rsp_valid, t4_psel, t4_penable, t4_rsp_err, t4_rsp_rdata, exp_err, exp_rd); bad++;
            end
            t4_rsp_ready = 1'b1;
            @(posedge pclk); #1;
            t4_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic        serr;
        for (int n = 0; n < 20; n++) begin
            wr   = 1'($urandom);
            serr = ($urandom_range(0, 3) == 0);
            drive_xfer(5'($urandom), $urandom, wr, $urandom_range(0, 6), serr, $urandom,
                       $urandom_range(0, 3), "random");
        end
    endtask

    // Ten requests with rsp_ready held high against a memory-backed slave;
    // expected read data comes from an independent reference memory.
    task automatic test_back_to_back();
        logic [4:0]  ba[10];
        logic [31:0] bd[10];
        logic        bw[10];
        int          acc_cyc[10];
        logic [31:0] smem[32];
        logic [31:0] ref_mem[32];
        logic [32:0] e;
        logic        acc_now;
        int          i;
        int          got;
        for (int m = 0; m < 32; m++) begin
            ref_mem[m] = $urandom;
            smem[m]    = ref_mem[m];
        end
        for (int m = 0; m < 10; m++) begin
            ba[m] = 5'($urandom_range(0, 3));
            bd[m] = $urandom;
            bw[m] = 1'($urandom);
            acc_cyc[m] = 0;
        end
        exp_q.delete();
        i = 0; got = 0;
        @(negedge pclk);
        pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = ba[0]; req_wdata = bd[0]; req_write = bw[0];
        for (int c = 0; c < 200 && got < 10; c++) begin
            if (c > 0) @(negedge pclk);
            if (rsp_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_rsp: unexpected response err=%b rdata=%h", rsp_err, rsp_rdata); bad++;
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_rdata} !== e) begin
                        $display("FAIL b2b_rsp_%0d: err=%b rdata=%h want %b %h", got, rsp_err, rsp_rdata, e[32], e[31:0]); bad++;
                    end
                end
                got++;
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                prdata = pwrite ? $urandom : smem[paddr];
                if (pwrite) smem[paddr] = pwdata;
            end
            acc_now = req_valid && req_ready;
            @(posedge pclk); #1;
            if (acc_now) begin
                acc_cyc[i] = c;
                exp_q.push_back({1'b0, bw[i] ? 32'd0 : ref_mem[ba[i]]});
                if (bw[i]) ref_mem[ba[i]] = bd[i];
                i++;
                if (i < 10) begin
                    req_addr = ba[i]; req_wdata = bd[i]; req_write = bw[i];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        pready = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
        total++;
        if (got !== 10) begin
            $display("FAIL b2b_count: got %0d responses want 10", got); bad++;
        end
        for (int m = 1; m < 10; m++) begin
            total++;
            if (acc_cyc[m] - acc_cyc[m-1] !== 4) begin
                $display("FAIL b2b_period_%0d: got %0d cycles want 4", m, acc_cyc[m] - acc_cyc[m-1]); bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge pclk);
        req_valid = 1'b1; req_addr = 5'h15; req_wdata = $urandom; req_write = 1'b1; pready = 1'b0;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        total++;
        if ({psel, penable} !== 2'b11) begin
            $display("FAIL rstmid_in_access: psel=%b penable=%b want 1 1", psel, penable); bad++;
        end
        #2;
        presetn = 1'b0;
        #1;
        total++;
        if ({psel, penable, rsp_valid, req_ready, paddr, pwdata, pwrite, rsp_err, rsp_rdata} !== '0) begin
            $display("FAIL rstmid_async: psel=%b penable=%b rsp_valid=%b req_ready=%b paddr=%h pwdata=%h pwrite=%b want all 0",
                     psel, penable, rsp_valid, req_ready, paddr, pwdata, pwrite); bad++;
        end
        @(posedge pclk);
        @(negedge pclk); #2;
        presetn = 1'b1;
        #1;
        total++;
        if ({req_ready, psel, rsp_valid} !== 3'b100) begin
            $display("FAIL rstmid_release: req_ready=%b psel=%b rsp_valid=%b want 1 0 0", req_ready, psel, rsp_valid); bad++;
        end
        drive_xfer(5'h07, $urandom, 1'b0, 2, 1'b0, 32'h0BAD_F00D, 0, "rstmid_after");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_no_timeout();
        test_timeout();
        test_resp_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
